mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the instruction-fetch requester (I) and the data-access requester (D).
- D requests come from the MEM stage, after memdec byte-lane decode; D supplies a 4-bit write enable and a lane-replicated write data word.
- A 4-state FSM sequences each transaction: arbitrate, address phase, data phase, response.
- Registered request and response paths keep the core's critical path off the bus.

---
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch (I) and data-access (D) requesters onto one
// SRAM-like bus, one transaction at a time, with registered request/response paths.
module mem_bus_arbiter #(
    parameter bit RR_EN = 1'b0,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [3:0]    d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic          d_kill,
    output logic          d_ready,
    output logic [31:0]   d_rdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    // Bus handshake: mem_req is held with stable fields until the cycle mem_addr_ok
    // is sampled high; mem_rdata is taken only on the edge mem_data_ok is high in DATA.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nx;

    logic gnt_d;      // 1 = current transaction belongs to D
    logic last_d;     // 1 = most recent grant went to D
    logic i_elig, d_elig;
    logic grant, pick_d, local_done;

    assign i_elig = i_req;
    assign d_elig = d_req && !d_kill;

    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        pick_d     = 1'b0;
        local_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_elig || d_elig) begin
                    grant = 1'b1;
                    if (RR_EN && i_elig && d_elig) pick_d = !last_d;
                    else                           pick_d = d_elig;
                    // A store with no enabled lanes completes without touching the bus
                    local_done = pick_d && d_wr && (d_wen == 4'b0000);
                    state_nx   = local_done ? RESP : ADDR;
                end
            end
            ADDR:    if (mem_addr_ok) state_nx = DATA;
            DATA:    if (mem_data_ok) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wen   <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant) begin
                gnt_d  <= pick_d;
                last_d <= pick_d;
            end
            if (grant && !local_done) begin
                mem_req   <= 1'b1;
                mem_wr    <= pick_d && d_wr;
                mem_wen   <= pick_d ? d_wen   : 4'b0000;
                mem_addr  <= pick_d ? d_addr  : i_addr;
                mem_wdata <= pick_d ? d_wdata : 32'h0;
            end
            if (state == ADDR && mem_addr_ok) mem_req <= 1'b0;
            if (state == DATA && mem_data_ok) begin
                if (gnt_d) d_rdata <= mem_rdata;
                else       i_rdata <= mem_rdata;
            end
            if (local_done) d_rdata <= 32'h0;
        end
    end

    assign i_ready   = (state == RESP) && !gnt_d;
    assign d_ready   = (state == RESP) && gnt_d;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance, a bus
// responder with configurable waits, and a scoreboard of expected ready/rdata.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk, resetn;
    logic        i_req, d_req, d_wr, d_kill;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wen;
    logic        mem_addr_ok, mem_data_ok;
    logic        sel_rr;

    logic        f_i_ready, f_d_ready, f_mem_req, f_mem_wr, f_busy;
    logic [31:0] f_i_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wen;
    logic [1:0]  f_state;
    logic        r_i_ready, r_d_ready, r_mem_req, r_mem_wr, r_busy;
    logic [31:0] r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_wen;
    logic [1:0]  r_state;

    // only the selected instance sees requests and bus responses
    mem_bus_arbiter #(.RR_EN(1'b0), .AW(32)) u_fp (
        .clk(clk), .resetn(resetn),
        .i_req(i_req && !sel_rr), .i_addr(i_addr), .i_ready(f_i_ready), .i_rdata(f_i_rdata),
        .d_req(d_req && !sel_rr), .d_wr(d_wr), .d_wen(d_wen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_kill(d_kill), .d_ready(f_d_ready), .d_rdata(f_d_rdata),
        .mem_req(f_mem_req), .mem_wr(f_mem_wr), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_addr_ok(mem_addr_ok && !sel_rr),
        .mem_data_ok(mem_data_ok && !sel_rr), .mem_rdata(mem_rdata),
        .busy(f_busy), .state_dbg(f_state)
    );

    mem_bus_arbiter #(.RR_EN(1'b1), .AW(32)) u_rr (
        .clk(clk), .resetn(resetn),
        .i_req(i_req && sel_rr), .i_addr(i_addr), .i_ready(r_i_ready), .i_rdata(r_i_rdata),
        .d_req(d_req && sel_rr), .d_wr(d_wr), .d_wen(d_wen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_kill(d_kill), .d_ready(r_d_ready), .d_rdata(r_d_rdata),
        .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_wen(r_mem_wen), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_addr_ok(mem_addr_ok && sel_rr),
        .mem_data_ok(mem_data_ok && sel_rr), .mem_rdata(mem_rdata),
        .busy(r_busy), .state_dbg(r_state)
    );

    wire        o_i_ready   = sel_rr ? r_i_ready   : f_i_ready;
    wire        o_d_ready   = sel_rr ? r_d_ready   : f_d_ready;
    wire        o_mem_req   = sel_rr ? r_mem_req   : f_mem_req;
    wire        o_mem_wr    = sel_rr ? r_mem_wr    : f_mem_wr;
    wire        o_busy      = sel_rr ? r_busy      : f_busy;
    wire [31:0] o_i_rdata   = sel_rr ? r_i_rdata   : f_i_rdata;
    wire [31:0] o_d_rdata   = sel_rr ? r_d_rdata   : f_d_rdata;
    wire [31:0] o_mem_addr  = sel_rr ? r_mem_addr  : f_mem_addr;
    wire [31:0] o_mem_wdata = sel_rr ? r_mem_wdata : f_mem_wdata;
    wire [3:0]  o_mem_wen   = sel_rr ? r_mem_wen   : f_mem_wen;
    wire [1:0]  o_state     = sel_rr ? r_state     : f_state;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];   // {is_d, rdata} in expected completion order
    bus_t        bus_q[$];   // bus fields in expected issue order
    int addr_delay = 0, data_delay = 0, req_cycles = 0;
    bit noise = 0;
    logic [31:0] last_i_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return a ^ 32'hA5A5_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    // bus responder: checks issued fields every mem_req cycle, then acks after the set waits
    initial begin : bus_model
        int ph, cnt;
        bus_t e;
        ph = 0; cnt = 0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
            if (!resetn) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                mem_data_ok = noise;
                if (o_mem_req) begin
                    req_cycles++;
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_mem_req: got addr %h exp no request", o_mem_addr);
                    end else begin
                        e = bus_q[0];
                        if (o_mem_wr !== e.wr || o_mem_wen !== e.wen || o_mem_addr !== e.addr ||
                            (e.wr && o_mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL bus_fields: got wr=%b wen=%b addr=%h wdata=%h exp wr=%b wen=%b addr=%h wdata=%h",
                                     o_mem_wr, o_mem_wen, o_mem_addr, o_mem_wdata, e.wr, e.wen, e.addr, e.wdata);
                        end
                    end
                    if (cnt == addr_delay) begin
                        mem_addr_ok = 1'b1;
                        mem_data_ok = 1'b0;
                        ph = 1; cnt = 0;
                        if (bus_q.size() != 0) void'(bus_q.pop_front());
                    end else cnt++;
                end
            end else begin
                if (cnt == data_delay) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = bus_word(o_mem_addr);
                    ph = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    // scoreboard: every ready pulse must match the head of exp_q
    initial begin : ready_monitor
        logic [32:0] e;
        logic [32:0] got;
        forever begin
            @(negedge clk);
            if (resetn && (o_i_ready || o_d_ready)) begin
                checks++;
                got = {o_d_ready, o_d_ready ? o_d_rdata : o_i_rdata};
                if (o_i_ready && o_d_ready) begin
                    errors++;
                    $display("FAIL both_ready: got i_ready=1 d_ready=1 exp one only");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got %h exp none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL ready_data: got {is_d,rdata}=%h exp %h", got, e);
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        bus_q.delete();
        resetn = 1'b1;
    endtask

    task automatic issue_i(input logic [31:0] a, output int lat);
        bus_q.push_back({1'b0, 4'b0000, a, 32'h0});
        exp_q.push_back({1'b0, bus_word(a)});
        last_i_data = bus_word(a);
        @(negedge clk);
        i_req = 1'b1; i_addr = a; lat = 1;
        while (!o_i_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        i_req = 1'b0;
    endtask

    task automatic issue_d(input logic wr, input logic [3:0] wen, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
        if (wr && wen == 4'b0000) exp_q.push_back({1'b1, 32'h0});
        else begin
            bus_q.push_back({wr, wen, a, wd});
            exp_q.push_back({1'b1, bus_word(a)});
        end
        @(negedge clk);
        d_req = 1'b1; d_wr = wr; d_wen = wen; d_addr = a; d_wdata = wd; lat = 1;
        while (!o_d_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", o_busy); end
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", o_mem_req); end
        checks++; if ({o_i_ready, o_d_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", {o_i_ready, o_d_ready}); end
        checks++; if (o_i_rdata !== 32'h0 || o_d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h exp 0/0", o_i_rdata, o_d_rdata); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", o_state); end
        reset_dut();
    endtask

    task automatic test_single_read();
        int lat;
        req_cycles = 0;
        issue_i(32'hBFC0_0000, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d exp 4", lat); end
        checks++; if (req_cycles !== 1) begin errors++; $display("FAIL read_req_cycles: got %0d exp 1", req_cycles); end
        checks++; if (o_i_rdata !== 32'h3C08_0001) begin errors++; $display("FAIL read_rdata: got %h exp 3c080001", o_i_rdata); end
    endtask

    task automatic test_priority();
        int n, i_lat, d_lat;
        i_lat = 0; d_lat = 0;
        bus_q.push_back({1'b1, 4'b0100, 32'h8000_0002, 32'hABAB_ABAB});
        bus_q.push_back({1'b0, 4'b0000, 32'hBFC0_0010, 32'h0});
        exp_q.push_back({1'b1, bus_word(32'h8000_0002)});
        exp_q.push_back({1'b0, bus_word(32'hBFC0_0010)});
        last_i_data = bus_word(32'hBFC0_0010);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0010;
        d_req = 1'b1; d_wr = 1'b1; d_wen = 4'b0100; d_addr = 32'h8000_0002; d_wdata = 32'hABAB_ABAB;
        n = 1;
        while ((i_req || d_req) && n < 60) begin
            @(negedge clk);
            n++;
            if (o_d_ready) begin d_req = 1'b0; d_lat = n; end
            if (o_i_ready) begin i_req = 1'b0; i_lat = n; end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++; if (d_lat !== 4) begin errors++; $display("FAIL prio_d_cycle: got %0d exp 4", d_lat); end
        checks++; if (i_lat !== 8) begin errors++; $display("FAIL prio_i_cycle: got %0d exp 8", i_lat); end
    endtask

    task automatic test_wait_states();
        int lat;
        addr_delay = 3; data_delay = 1; noise = 1; req_cycles = 0;
        issue_i(32'h0040_1230, lat);
        addr_delay = 0; data_delay = 0; noise = 0;
        checks++; if (lat !== 8) begin errors++; $display("FAIL wait_latency: got %0d exp 8", lat); end
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL wait_req_cycles: got %0d exp 4", req_cycles); end
    endtask

    task automatic test_misaligned();
        int lat;
        logic [31:0] ra;
        ra = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
        issue_d(1'b0, 4'b1111, ra, 32'h0, lat);
        req_cycles = 0;
        issue_d(1'b1, 4'b0000, 32'h8000_0001, 32'h1234_5678, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_latency: got %0d exp 2", lat); end
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL misalign_req_cycles: got %0d exp 0", req_cycles); end
        checks++; if (o_i_rdata !== last_i_data) begin errors++; $display("FAIL i_rdata_hold: got %h exp %h", o_i_rdata, last_i_data); end
    endtask

    task automatic test_kill();
        int lat;
        bus_q.push_back({1'b0, 4'b0000, 32'hBFC0_0100, 32'h0});
        exp_q.push_back({1'b0, bus_word(32'hBFC0_0100)});
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0100;
        d_req = 1'b1; d_wr = 1'b0; d_wen = 4'b1111; d_addr = 32'h8000_0040; d_kill = 1'b1;
        lat = 1;
        while (!o_i_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        i_req = 1'b0; d_req = 1'b0; d_kill = 1'b0;
        checks++; if (lat !== 4) begin errors++; $display("FAIL kill_i_latency: got %0d exp 4", lat); end
        repeat (3) @(negedge clk);
        addr_delay = 2;
        bus_q.push_back({1'b0, 4'b1111, 32'h8000_0080, 32'h0});
        exp_q.push_back({1'b1, bus_word(32'h8000_0080)});
        d_req = 1'b1; d_addr = 32'h8000_0080; lat = 1;
        @(negedge clk);
        lat++;
        d_kill = 1'b1;
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL kill_in_addr_state: got %0d exp 1", o_state); end
        while (!o_d_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d_req = 1'b0; d_kill = 1'b0; addr_delay = 0;
        checks++; if (lat !== 6) begin errors++; $display("FAIL kill_late_latency: got %0d exp 6", lat); end
    endtask

    task automatic test_reset_in_data();
        int n, lat;
        data_delay = 6;
        bus_q.push_back({1'b0, 4'b0000, 32'hBFC0_0200, 32'h0});
        exp_q.push_back({1'b0, bus_word(32'hBFC0_0200)});
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'hBFC0_0200; n = 0;
        while (o_state !== 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL reach_data: got state %0d exp 2", o_state); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b exp 0", o_busy); end
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL async_mem_req: got %b exp 0", o_mem_req); end
        checks++; if ({o_i_ready, o_d_ready} !== 2'b00) begin errors++; $display("FAIL async_ready: got %b exp 00", {o_i_ready, o_d_ready}); end
        checks++; if (o_i_rdata !== 32'h0) begin errors++; $display("FAIL async_i_rdata: got %h exp 0", o_i_rdata); end
        i_req = 1'b0; data_delay = 0;
        exp_q.delete(); bus_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        issue_i(32'hBFC0_0204, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_latency: got %0d exp 4", lat); end
    endtask

    task automatic test_round_robin();
        logic [31:0] ia[2];
        logic [31:0] da[2];
        int ic, dc, n;
        sel_rr = 1'b1;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            ia[k] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            da[k] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        end
        for (int k = 0; k < 2; k++) begin
            bus_q.push_back({1'b0, 4'b1111, da[k], 32'h0});
            bus_q.push_back({1'b0, 4'b0000, ia[k], 32'h0});
            exp_q.push_back({1'b1, bus_word(da[k])});
            exp_q.push_back({1'b0, bus_word(ia[k])});
        end
        @(negedge clk);
        i_req = 1'b1; i_addr = ia[0];
        d_req = 1'b1; d_wr = 1'b0; d_wen = 4'b1111; d_addr = da[0];
        ic = 0; dc = 0; n = 0;
        while ((i_req || d_req) && n < 100) begin
            @(negedge clk);
            n++;
            if (o_d_ready) begin dc++; if (dc < 2) d_addr = da[dc]; else d_req = 1'b0; end
            if (o_i_ready) begin ic++; if (ic < 2) i_addr = ia[ic]; else i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++; if (ic !== 2 || dc !== 2) begin errors++; $display("FAIL rr_done: got i=%0d d=%0d exp 2/2", ic, dc); end
    endtask

    initial begin
        resetn = 1'b0; sel_rr = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_kill = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wen = 4'b0000;
        last_i_data = 32'h0;
        test_reset();
        test_single_read();
        test_priority();
        test_wait_states();
        test_misaligned();
        test_kill();
        test_reset_in_data();
        test_round_robin();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: got %0d/%0d pending exp 0/0", exp_q.size(), bus_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
